dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Cache controller for the 2-way 16-set write-back L1 data cache.
- Sits between the CPU pipeline's MEM stage, the dcache SRAM array (tag/data/hit storage with LRU victim selection) and the off-chip data memory.
- Decodes CPU addresses, drives SRAM index/tag/data/write, merges 32-bit CPU words into 256-bit lines, and sequences write-back and refill on a miss while stalling the CPU.

Parameters:
- ADDR_W, 32, CPU/memory byte address width
- WORD_W, 32, CPU data width
- LINE_W, 256, cache line width (32 bytes, 8 words)
- INDEX_W, 4, set index width (16 sets)
- TAG_W, 23, address tag width; SRAM tag field = {valid, dirty, tag} = 25 bits

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cpu_addr_i  in  32  byte address; tag=[31:9], index=[8:5], word=[4:2]
- cpu_data_i  in  32  store data
- cpu_MemRead_i  in  1  load request
- cpu_MemWrite_i  in  1  store request
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  hold pipeline
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  {valid, dirty, tag} to SRAM
- sram_data_o  out  256  line to SRAM
- sram_enable_o  out  1  SRAM access
- sram_write_o  out  1  SRAM write strobe
- sram_tag_i  in  25  hit way tag, or LRU victim tag on miss
- sram_data_i  in  256  hit way line, or LRU victim line on miss
- sram_hit_i  in  1  tag match with valid
- mem_addr_o  out  32  line-aligned memory address ([4:0]=0)
- mem_data_o  out  256  write-back line
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1=write-back, 0=refill read
- mem_data_i  in  256  refill line
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- req = cpu_MemRead_i | cpu_MemWrite_i; both high is treated as a store.
- sram_addr_o = cpu_addr_i[8:5] always; sram_enable_o = req.
- State machine states: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE.
- Reset: state=IDLE, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0. Reset mid-operation abandons the transaction; a mem_ack_i arriving in IDLE is ignored.
- IDLE, read hit (req & sram_hit_i): cpu_data_o = sram_data_i[word*32 +: 32] combinationally, cpu_stall_o=0, no SRAM write. Zero added latency.
- IDLE, write hit:
  - sram_write_o=1 same cycle.
  - sram_data_o = sram_data_i with selected word replaced by cpu_data_i.
  - sram_tag_o = {1,1,cpu tag}.
  - cpu_stall_o=0.
- IDLE, miss (req & !sram_hit_i): cpu_stall_o=1 combinationally; next state MISS.
- cpu_stall_o=1 in every non-IDLE state. cpu_data_o=0 when no read hit.
- MISS, one cycle, evaluates the victim from sram_tag_i:
  - If valid&dirty (bits[24:23]=2'b11): register mem_addr_o={victim tag, index, 5'b0}, mem_data_o=sram_data_i, mem_write_o=1, mem_enable_o=1; go to WRITEBACK.
  - Else: mem_addr_o={cpu tag, index, 5'b0}, mem_write_o=0, mem_enable_o=1; go to REFILL.
- WRITEBACK:
  - Memory outputs are held stable until mem_ack_i.
  - On ack, in the same edge: load refill address, mem_write_o=0, mem_enable_o stays 1; go to REFILL.
- REFILL: hold outputs; on mem_ack_i, mem_enable_o=0 and go to REFILL_DONE.
  - Refill data is registered at the ack edge.
- REFILL_DONE, one cycle:
  - sram_write_o=1, sram_data_o = registered refill line, sram_tag_o={1,0,cpu tag}. The SRAM places it in the LRU way.
  - Go to IDLE; the request then re-evaluates as a hit.
  - For a store, the write-hit path then merges the word and sets dirty.
- Miss penalty: 3 cycles + memory latency (clean victim); add one memory transaction for a dirty victim.
- mem_ack_i in IDLE or MISS is ignored. The CPU holds address and data stable while stalled.

Decomposition:
- Shared package dcache_pkg:
  - field positions: TAG_HI=31, TAG_LO=9, IDX_HI=8, IDX_LO=5, WORD_HI=4, WORD_LO=2
  - VALID_BIT=24, DIRTY_BIT=23
  - state encoding constants
- One natural sub-module: line_word_merge. Combinational 256-bit word select (read) and word insert (write) by 3-bit offset.
- FSM and muxing stay in dcache_controller.

Test Plan:
- Cold read at 0x0000_0040: miss, no write-back, mem_addr_o=0x40 read. Ack with line whose word0=0xDEADBEEF. REFILL_DONE writes tag {1,0,0}. Next cycle cpu_data_o=0xDEADBEEF, stall drops.
- Read hit: same address again -> stall 0 in the same cycle, no mem_enable_o.
- Store 0x12345678 to 0x0000_0044 after the fill: write hit. sram_tag_o={1,1,0}, word1 replaced in sram_data_o, other words unchanged.
- Dirty eviction:
  - Setup: fill both ways of set 2 (0x40, 0x240), dirty one of them. Then read 0x440 with the dirty line as LRU victim.
  - Required: WRITEBACK to the victim address with the old line. After ack, refill read of 0x440 with no idle cycle between transactions. Stall drops only after REFILL_DONE.
- Store miss to a clean set: refill then merge. Final SRAM line holds refill data with the store word, dirty=1.
- Assert rst_i during REFILL, then pulse mem_ack_i after reset: state IDLE, mem_enable_o=0, no SRAM write, ack ignored.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, address field positions, SRAM tag bits and FSM states for the L1 dcache controller
// Contents: ADDR_W/WORD_W/LINE_W/INDEX_W/TAG_W widths, address field bounds, VALID/DIRTY bit positions, state_e
package dcache_pkg;
    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = 256;
    localparam int INDEX_W    = 4;
    localparam int TAG_W      = 23;
    localparam int SRAM_TAG_W = TAG_W + 2;
    localparam int TAG_HI     = 31;
    localparam int TAG_LO     = 9;
    localparam int IDX_HI     = 8;
    localparam int IDX_LO     = 5;
    localparam int WORD_HI    = 4;
    localparam int WORD_LO    = 2;
    localparam int VALID_BIT  = 24;
    localparam int DIRTY_BIT  = 23;
    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_MISS        = 3'd1,
        S_WRITEBACK   = 3'd2,
        S_REFILL      = 3'd3,
        S_REFILL_DONE = 3'd4
    } state_e;
endpackage

// File: rtl/dcache_controller_line_word_merge.sv
// line_word_merge: selects one 32-bit word from a 256-bit line and builds the line with that word replaced
// Ports: line_i (source line), word_i (insert word), offset_i (word offset), word_o (selected word), line_o (merged line)
module line_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0]          line_i,
    input  logic [WORD_W-1:0]          word_i,
    input  logic [WORD_HI-WORD_LO:0]   offset_i,
    output logic [WORD_W-1:0]          word_o,
    output logic [LINE_W-1:0]          line_o
);
    logic [7:0] base;
    assign base   = {offset_i, 5'b0};
    assign word_o = line_i[base +: WORD_W];
    always_comb begin
        line_o = line_i;
        line_o[base +: WORD_W] = word_i;
    end
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: 2-way 16-set write-back L1 dcache controller; hit path, word merge, write-back/refill sequencing
// Ports: clk_i/rst_i; cpu_* (MEM-stage request, load data, stall); sram_* (index/tag/line/strobes to and from the array);
//        mem_* (line-aligned request, write-back line, refill line, one-cycle ack)
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_W-1:0]     cpu_addr_i,
    input  logic [WORD_W-1:0]     cpu_data_i,
    input  logic                  cpu_MemRead_i,
    input  logic                  cpu_MemWrite_i,
    output logic [WORD_W-1:0]     cpu_data_o,
    output logic                  cpu_stall_o,
    output logic [INDEX_W-1:0]    sram_addr_o,
    output logic [SRAM_TAG_W-1:0] sram_tag_o,
    output logic [LINE_W-1:0]     sram_data_o,
    output logic                  sram_enable_o,
    output logic                  sram_write_o,
    input  logic [SRAM_TAG_W-1:0] sram_tag_i,
    input  logic [LINE_W-1:0]     sram_data_i,
    input  logic                  sram_hit_i,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [LINE_W-1:0]     mem_data_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    input  logic [LINE_W-1:0]     mem_data_i,
    input  logic                  mem_ack_i
);
    state_e              state_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [LINE_W-1:0]   mem_data_q;
    logic [LINE_W-1:0]   refill_q;
    logic                mem_enable_q;
    logic                mem_write_q;
    logic                req;
    logic                idle;
    logic                hit;
    logic                fill_done;
    logic [TAG_W-1:0]    cpu_tag;
    logic [INDEX_W-1:0]  index;
    logic [WORD_W-1:0]   hit_word;
    logic [LINE_W-1:0]   merged_line;
    logic [ADDR_W-1:0]   refill_addr_d;
    logic [ADDR_W-1:0]   victim_addr_d;
    logic                unused_bits;
    assign unused_bits   = ^cpu_addr_i[WORD_LO-1:0];
    assign cpu_tag       = cpu_addr_i[TAG_HI:TAG_LO];
    assign index         = cpu_addr_i[IDX_HI:IDX_LO];
    assign req           = cpu_MemRead_i | cpu_MemWrite_i;
    assign idle          = state_q == S_IDLE;
    assign hit           = idle & req & sram_hit_i;
    assign fill_done     = state_q == S_REFILL_DONE;
    assign refill_addr_d = {cpu_tag, index, {(WORD_HI + 1){1'b0}}};
    assign victim_addr_d = {sram_tag_i[TAG_W-1:0], index, {(WORD_HI + 1){1'b0}}};
    line_word_merge u_merge (
        .line_i   (sram_data_i),
        .word_i   (cpu_data_i),
        .offset_i (cpu_addr_i[WORD_HI:WORD_LO]),
        .word_o   (hit_word),
        .line_o   (merged_line)
    );
    // A store wins when both request lines are high, so only a pure load returns data.
    assign cpu_data_o    = (hit & ~cpu_MemWrite_i) ? hit_word : '0;
    assign cpu_stall_o   = ~idle | (req & ~sram_hit_i);
    assign sram_addr_o   = index;
    assign sram_enable_o = req;
    assign sram_write_o  = (hit & cpu_MemWrite_i) | fill_done;
    // Refilled lines are installed clean; a pending store re-hits next cycle and sets dirty.
    assign sram_tag_o    = {1'b1, ~fill_done, cpu_tag};
    assign sram_data_o   = fill_done ? refill_q : merged_line;
    assign mem_addr_o    = mem_addr_q;
    assign mem_data_o    = mem_data_q;
    assign mem_enable_o  = mem_enable_q;
    assign mem_write_o   = mem_write_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            refill_q     <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (req && !sram_hit_i) state_q <= S_MISS;
                S_MISS: begin
                    mem_enable_q <= 1'b1;
                    if (sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT]) begin
                        mem_addr_q  <= victim_addr_d;
                        mem_data_q  <= sram_data_i;
                        mem_write_q <= 1'b1;
                        state_q     <= S_WRITEBACK;
                    end else begin
                        mem_addr_q  <= refill_addr_d;
                        mem_write_q <= 1'b0;
                        state_q     <= S_REFILL;
                    end
                end
                // Chain straight into the refill read so memory sees no idle cycle.
                S_WRITEBACK: if (mem_ack_i) begin
                    mem_addr_q  <= refill_addr_d;
                    mem_write_q <= 1'b0;
                    state_q     <= S_REFILL;
                end
                S_REFILL: if (mem_ack_i) begin
                    mem_enable_q <= 1'b0;
                    refill_q     <= mem_data_i;
                    state_q      <= S_REFILL_DONE;
                end
                S_REFILL_DONE: state_q <= S_IDLE;
                default:       state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: scoreboard bench with a 2-way LRU SRAM model and a fixed-latency line memory
module tb_dcache_controller;
    localparam int LAT     = 2;
    localparam int MEM_CYC = LAT + 1;
    localparam int CLEAN   = 3 + MEM_CYC;
    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } mem_txn_t;
    logic         clk = 1'b0;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic         auto_ack;
    logic         man_ack;
    logic         mem_auto;
    logic         mdl_clr;
    int           n_chk = 0;
    int           n_err = 0;
    mem_txn_t     mem_exp_q [$];
    logic [31:0]  rd_q [$];
    logic [31:0]  gold [logic [31:0]];
    logic [255:0] mem [logic [31:0]];
    logic [24:0]  s_tag [2][16];
    logic [255:0] s_dat [2][16];
    logic         s_lru [16];
    logic         h0, h1, hw, ww;
    int           wr_cnt;
    logic [24:0]  last_wtag;

    always #5 clk = ~clk;
    assign mem_ack_i = auto_ack | man_ack;

    dcache_controller dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .sram_addr_o    (sram_addr_o),
        .sram_tag_o     (sram_tag_o),
        .sram_data_o    (sram_data_o),
        .sram_enable_o  (sram_enable_o),
        .sram_write_o   (sram_write_o),
        .sram_tag_i     (sram_tag_i),
        .sram_data_i    (sram_data_i),
        .sram_hit_i     (sram_hit_i),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        logic [31:0] k;
        k = a & ~32'd3;
        return gold.exists(k) ? gold[k] : init_word(k);
    endfunction

    function automatic logic [255:0] gold_line(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  b;
        b = a & ~32'd31;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = gold_word(b + 32'(i * 4));
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] l;
        if (mem.exists(a)) return mem[a];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(a + 32'(i * 4));
        return l;
    endfunction

    // 2-way SRAM array: returns the hit way, else the LRU victim way
    always_comb begin
        h0 = s_tag[0][sram_addr_o][24] && s_tag[0][sram_addr_o][22:0] == cpu_addr_i[31:9];
        h1 = s_tag[1][sram_addr_o][24] && s_tag[1][sram_addr_o][22:0] == cpu_addr_i[31:9];
        hw = ~h0 & h1;
        sram_hit_i = h0 | h1;
        ww = sram_hit_i ? hw : s_lru[sram_addr_o];
        sram_tag_i = s_tag[ww][sram_addr_o];
        sram_data_i = s_dat[ww][sram_addr_o];
    end

    always @(posedge clk) begin
        if (mdl_clr) begin
            for (int w = 0; w < 2; w++)
                for (int s = 0; s < 16; s++) begin
                    s_tag[w][s] <= '0;
                    s_dat[w][s] <= '0;
                end
            for (int s = 0; s < 16; s++) s_lru[s] <= 1'b0;
            wr_cnt <= 0;
            last_wtag <= '0;
        end else if (sram_enable_o) begin
            if (sram_write_o) begin
                s_tag[ww][sram_addr_o] <= sram_tag_o;
                s_dat[ww][sram_addr_o] <= sram_data_o;
                s_lru[sram_addr_o] <= ~ww;
                wr_cnt <= wr_cnt + 1;
                last_wtag <= sram_tag_o;
            end else if (sram_hit_i) begin
                s_lru[sram_addr_o] <= ~hw;
            end
        end
    end

    // Memory responder: acks LAT negedges after a request is seen, checks each transaction against the queue
    initial begin
        int       cnt;
        logic     wb_follow;
        mem_txn_t e;
        cnt = 0;
        wb_follow = 1'b0;
        auto_ack = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            auto_ack = 1'b0;
            if (wb_follow) begin
                check("wb_then_refill_en", 256'(mem_enable_o), 256'(1'b1));
                check("wb_then_refill_rd", 256'(mem_write_o), 256'(1'b0));
                wb_follow = 1'b0;
            end
            if (!mem_auto || !mem_enable_o) cnt = 0;
            else if (cnt < LAT) cnt++;
            else begin
                cnt = 0;
                auto_ack = 1'b1;
                if (mem_exp_q.size() == 0) check("mem_unexpected", 256'(mem_addr_o), 256'(0));
                else begin
                    e = mem_exp_q.pop_front();
                    check("mem_write", 256'(mem_write_o), 256'(e.wr));
                    check("mem_addr", 256'(mem_addr_o), 256'(e.addr));
                    if (e.wr) begin
                        check("mem_wb_line", mem_data_o, e.data);
                        mem[mem_addr_o] = mem_data_o;
                        wb_follow = 1'b1;
                    end else mem_data_i = mem_line(mem_addr_o);
                end
            end
        end
    end

    task automatic push_mem(input logic wr, input logic [31:0] a, input logic [255:0] d);
        mem_txn_t e;
        e.wr = wr;
        e.addr = a;
        e.data = d;
        mem_exp_q.push_back(e);
    endtask

    task automatic access(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] d, input int exp_cyc);
        int cyc;
        logic [31:0] exp;
        cyc = 0;
        @(negedge clk);
        cpu_addr_i = a;
        cpu_data_i = d;
        cpu_MemRead_i = ~wr;
        cpu_MemWrite_i = wr;
        if (wr) gold[a & ~32'd3] = d;
        else rd_q.push_back(gold_word(a));
        #1;
        while (cpu_stall_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_cycles"}, 256'(cyc), 256'(exp_cyc));
        if (wr) begin
            check({tag, "_sram_write"}, 256'(sram_write_o), 256'(1'b1));
            check({tag, "_sram_tag"}, 256'(sram_tag_o), 256'({2'b11, a[31:9]}));
            check({tag, "_sram_line"}, sram_data_o, gold_line(a));
        end else begin
            exp = rd_q.pop_front();
            check({tag, "_data"}, 256'(cpu_data_o), 256'(exp));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int wc0;
        rst_i = 1'b1;
        mdl_clr = 1'b1;
        mem_auto = 1'b1;
        man_ack = 1'b0;
        cpu_addr_i = '0;
        cpu_data_i = '0;
        cpu_MemRead_i = 1'b0;
        cpu_MemWrite_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        mdl_clr = 1'b0;
        #1;
        check("rst_stall", 256'(cpu_stall_o), 256'(1'b0));
        check("rst_mem_en", 256'(mem_enable_o), 256'(1'b0));
        check("rst_mem_wr", 256'(mem_write_o), 256'(1'b0));
        check("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        check("rst_mem_data", mem_data_o, 256'(0));
        check("rst_cpu_data", 256'(cpu_data_o), 256'(0));

        push_mem(1'b0, 32'h40, '0);
        access("cold_rd", 1'b0, 32'h40, 32'h0, CLEAN);
        check("cold_fill_tag", 256'(last_wtag), 256'({2'b10, 23'd0}));
        access("hit_rd", 1'b0, 32'h40, 32'h0, 0);
        check("hit_no_mem", 256'(mem_enable_o), 256'(1'b0));
        access("st_hit", 1'b1, 32'h44, 32'h12345678, 0);
        access("rd_back", 1'b0, 32'h44, 32'h0, 0);

        push_mem(1'b0, 32'h240, '0);
        access("fill_way1", 1'b0, 32'h248, 32'h0, CLEAN);
        push_mem(1'b1, 32'h40, gold_line(32'h40));
        push_mem(1'b0, 32'h440, '0);
        access("dirty_evict", 1'b0, 32'h440, 32'h0, CLEAN + MEM_CYC);
        access("evict_rd_w3", 1'b0, 32'h44C, 32'h0, 0);

        push_mem(1'b0, 32'h60, '0);
        access("st_miss", 1'b1, 32'h64, 32'hCAFEF00D, CLEAN);
        @(negedge clk);
        check("st_miss_tag", 256'(s_tag[0][3]), 256'({2'b11, 23'd0}));
        check("st_miss_line", s_dat[0][3], gold_line(32'h60));

        mem_auto = 1'b0;
        @(negedge clk);
        cpu_addr_i = 32'h840;
        cpu_MemRead_i = 1'b1;
        cpu_MemWrite_i = 1'b0;
        cyc = 0;
        #1;
        while (!mem_enable_o && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_in_refill", 256'({mem_enable_o, mem_write_o}), 256'(2'b10));
        check("abort_refill_addr", 256'(mem_addr_o), 256'(32'h840));
        @(negedge clk);
        wc0 = wr_cnt;
        rst_i = 1'b1;
        cpu_MemRead_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("abort_mem_en", 256'(mem_enable_o), 256'(1'b0));
        check("abort_mem_addr", 256'(mem_addr_o), 256'(0));
        check("abort_stall", 256'(cpu_stall_o), 256'(1'b0));
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        #1;
        check("idle_ack_mem_en", 256'(mem_enable_o), 256'(1'b0));
        check("idle_ack_stall", 256'(cpu_stall_o), 256'(1'b0));
        check("idle_ack_no_write", 256'(wr_cnt), 256'(wc0));
        mem_auto = 1'b1;
        access("post_rst_hit", 1'b0, 32'h240, 32'h0, 0);

        @(negedge clk);
        cpu_MemRead_i = 1'b0;
        cpu_MemWrite_i = 1'b0;
        repeat (2) @(negedge clk);
        check("mem_q_drained", 256'(mem_exp_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
